instr_loader: RTL and testbench
===============================

# instr_loader

Streaming writer for the instruction memory: it accepts a byte stream over a valid/ready handshake and assembles the bytes into INSTR_WIDTH-bit instructions. It writes those instructions into the writable instruction RAM at consecutive addresses starting from 0. It sits between the host link (UART/JTAG byte receiver) and the instruction RAM, and holds the CPU in reset until a complete program image has been loaded.

## Interface
- ADDR_WIDTH, 11, instruction address width; DEPTH = 2**ADDR_WIDTH; legal range 1..15
- INSTR_WIDTH, 9, instruction width; legal range 9..16 (always two bytes per instruction)
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  single-cycle pulse that begins a load; ignored unless the FSM is in IDLE, DONE or ERROR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  high in CNT_LO, CNT_HI, DATA_LO and DATA_HI only
- wr_en  out  1  one-cycle RAM write strobe
- wr_addr  out  ADDR_WIDTH  RAM write address
- wr_data  out  INSTR_WIDTH  RAM write data
- busy  out  1  high in any state other than IDLE, DONE or ERROR
- done  out  1  high in DONE
- err  out  1  high in ERROR
- cpu_hold  out  1  CPU reset request; low only in DONE

## Operation
- Image format, in this byte order:
  - count low byte, then count high byte; count = number of instructions
  - then, for each instruction, a low byte (bits 7:0) followed by a high byte (bits INSTR_WIDTH-1:8)
- States: IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI, DONE, ERROR.
- A byte is accepted on a cycle where in_valid && in_ready.
- Transitions:
  - IDLE/DONE/ERROR + start -> CNT_LO; the address counter is cleared on that edge.
  - CNT_LO --accept--> CNT_HI.
  - CNT_HI --accept--> DATA_LO if 1 <= count <= DEPTH, otherwise -> ERROR.
  - DATA_LO --accept--> DATA_HI.
  - DATA_HI --accept--> DATA_LO, or -> DONE if this was the last instruction.
- High-byte check: bits 7:(INSTR_WIDTH-8) must be zero. If any is set -> ERROR and no write occurs. The check does not apply when INSTR_WIDTH = 16.
- Write: when the high byte is accepted, wr_en, wr_addr and wr_data are registered so they are valid on the next cycle. The address counter then increments.
- Counters: the address/instruction counter is ADDR_WIDTH+1 bits wide, so count = DEPTH does not wrap. The last write goes to DEPTH-1.
- Bytes presented outside the accepting states are not consumed, because in_ready is low.
- start pulses while busy are ignored.
- Reset mid-load: all state returns to its reset value and no further writes occur. RAM contents already written are left as they are; the host must reload.

## Timing
- Reset values:
  - state IDLE
  - in_ready 0, wr_en 0, wr_addr 0, wr_data 0
  - busy 0, done 0, err 0
  - cpu_hold 1
- in_ready, busy, done, err and cpu_hold are registered state decodes; there is no combinational path from in_valid to in_ready.
- Latency: wr_en is high exactly 1 cycle after the high byte is accepted, and stays high for one cycle.
- done rises on the same cycle as the last wr_en. cpu_hold falls on that cycle too.
- Full throughput: with in_valid held high, one byte is accepted per cycle. A program of N instructions completes 2 + 2N accepting cycles after CNT_LO is entered.
- start while in DONE:
  - cpu_hold rises on the next cycle
  - done and err clear on the next cycle
- Back-to-back images: the first count byte may be accepted in the cycle immediately after CNT_LO is entered.

## Structure
- Package instr_loader_pkg holds:
  - the state enum type
  - localparam BYTES_PER_INSTR = 2
  - the count field width, CNT_WIDTH = 16
- Single module containing one FSM, a byte holding register for the low byte, and the address counter. No sub-module is needed.
- The instruction RAM is external. Its read port replaces the file-loaded ROM for synthesis builds.

## Test plan
- Load 3 instructions:
  - stimulus: bytes 03 00 | 5A 01 | FF 00 | 00 01
  - response: writes (0, 0x15A), (1, 0x0FF), (2, 0x100); done = 1, cpu_hold = 0, err = 0
- Throttled input: insert random in_valid gaps and de-assert in_valid between a low byte and its high byte. The same writes must occur in the same order, with no duplicate wr_en.
- Count = 0, and separately count = 2049 (0x0801) with ADDR_WIDTH = 11:
  - the FSM goes to ERROR, err = 1, no wr_en, cpu_hold = 1
  - a following start plus a valid image recovers
- Set a high-byte reserved bit, e.g. 02 00 | 11 02:
  - ERROR after that byte, no write for that instruction, err = 1
- Full depth: count = 0x0800. Addresses 0..2047 are each written once, the last at 2047, then done.
- Reset mid-load: assert rst_n low during DATA_HI:
  - all outputs return to their reset values at once
  - no wr_en afterwards
  - start plus a new image loads correctly from address 0

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned BYTES_PER_INSTR = 2;
  localparam int unsigned CNT_WIDTH       = 16;

endpackage

// File: rtl/instr_loader.sv
// Byte-stream loader: assembles two-byte instructions and writes them to the
// instruction RAM from address 0, holding the CPU in reset until done.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned INSTR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   cpu_hold
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CTR_W  = ADDR_WIDTH + 1;
  localparam int unsigned WORD_W = BYTES_PER_INSTR * 8;
  // Bits of the assembled word above the instruction width must be zero.
  localparam logic [WORD_W-1:0] RSVD_MASK = ~WORD_W'((64'(1) << INSTR_WIDTH) - 64'(1));

  state_t state_q, state_d;

  logic [7:0]           lo_byte_q;
  logic [CTR_W-1:0]     cnt_q;
  logic [CTR_W-1:0]     addr_q;
  logic                 accept;
  logic [CNT_WIDTH-1:0] cnt_word;
  logic [WORD_W-1:0]    instr_word;
  logic                 cnt_ok;
  logic                 hi_bad;
  logic                 last_instr;

  logic wr_en_d;
  logic clr_addr;
  logic in_ready_d, busy_d, done_d, err_d, cpu_hold_d;

  assign accept     = in_valid & in_ready;
  assign cnt_word   = CNT_WIDTH'({in_data, lo_byte_q});
  assign instr_word = WORD_W'({in_data, lo_byte_q});
  assign cnt_ok     = (cnt_word != '0) &&
                      ({1'b0, cnt_word} <= (CNT_WIDTH + 1)'(DEPTH));
  assign hi_bad     = |(instr_word & RSVD_MASK);
  assign last_instr = (addr_q + CTR_W'(1)) == cnt_q;

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    clr_addr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_CNT_LO;
          clr_addr = 1'b1;
        end
      end
      ST_CNT_LO:  if (accept) state_d = ST_CNT_HI;
      ST_CNT_HI:  if (accept) state_d = cnt_ok ? ST_DATA_LO : ST_ERROR;
      ST_DATA_LO: if (accept) state_d = ST_DATA_HI;
      ST_DATA_HI: begin
        if (accept) begin
          if (hi_bad) begin
            state_d = ST_ERROR;
          end else begin
            wr_en_d = 1'b1;
            state_d = last_instr ? ST_DONE : ST_DATA_LO;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) ||
                 (state_d == ST_DATA_LO) || (state_d == ST_DATA_HI);
    busy_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE) ||
                   (state_d == ST_ERROR));
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  // State register with registered status decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      cpu_hold <= cpu_hold_d;
    end
  end

  // Low-byte holding register, instruction count, address counter, write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_byte_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= wr_en_d;
      if (clr_addr) begin
        addr_q <= '0;
      end
      if (accept && ((state_q == ST_CNT_LO) || (state_q == ST_DATA_LO))) begin
        lo_byte_q <= in_data;
      end
      if (accept && (state_q == ST_CNT_HI) && cnt_ok) begin
        cnt_q <= CTR_W'(cnt_word);
      end
      if (wr_en_d) begin
        wr_addr <= addr_q[ADDR_WIDTH-1:0];
        wr_data <= instr_word[INSTR_WIDTH-1:0];
        addr_q  <= addr_q + CTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table of one-instruction images
// plus hand sequences; RAM writes are checked against a scoreboard queue.
module tb_instr_loader;

  localparam int unsigned AW = 11;
  localparam int unsigned IW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_hold;

  instr_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] c_lo;
    logic [7:0] c_hi;
    logic [7:0] d_lo;
    logic [7:0] d_hi;
    logic       has_data;
    logic       exp_err;
    logic [8:0] exp_data;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cyc_start = 0;
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
    end
  endfunction

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc_start = cyc;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_all(input bit throttle);
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      send_byte(b, throttle ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic push_instr(input logic [AW-1:0] a, input logic [IW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    tx_q.push_back(d[7:0]);
    tx_q.push_back({7'b0, d[8]});
    exp_q.push_back(w);
  endtask

  task automatic end_check(input logic exp_done, input logic exp_err);
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_err", 32'(err), 32'(exp_err));
    chk("end_hold", 32'(cpu_hold), 32'(!exp_done));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic load_three(input bit throttle);
    do_start();
    tx_q.push_back(8'h03);
    tx_q.push_back(8'h00);
    push_instr(11'd0, 9'h15A);
    push_instr(11'd1, 9'h0FF);
    push_instr(11'd2, 9'h100);
    void'(tx_q.pop_back());
    send_all(throttle);
    send_byte(8'h01, 0);
    chk("last_wr_en", 32'(wr_en), 32'd1);
    chk("done_with_last_wr", 32'(done), 32'd1);
    end_check(1'b1, 1'b0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h01, 8'h00, 8'h5A, 8'h01, 1'b1, 1'b0, 9'h15A};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 9'h000};
    tbl[2] = '{8'h01, 8'h00, 8'h34, 8'h00, 1'b1, 1'b0, 9'h034};
    tbl[3] = '{8'h01, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 9'h000};
    tbl[4] = '{8'h01, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 9'h1FF};
    tbl[5] = '{8'h02, 8'h00, 8'h11, 8'h02, 1'b1, 1'b1, 9'h000};
    tbl[6] = '{8'h01, 8'h00, 8'h00, 8'h80, 1'b1, 1'b1, 9'h000};
    tbl[7] = '{8'h01, 8'h00, 8'hAA, 8'h00, 1'b1, 1'b0, 9'h0AA};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ignores_bytes_ready", 32'(in_ready), 32'd0);

    // Basic 3-instruction image, with a start pulse while busy mid-load.
    do_start();
    tx_q = '{8'h03, 8'h00, 8'h5A, 8'h01};
    push_instr(11'd0, 9'h15A);
    void'(tx_q.pop_back());
    void'(tx_q.pop_back());
    send_all(1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_while_busy_ready", 32'(in_ready), 32'd1);
    chk("start_while_busy_busy", 32'(busy), 32'd1);
    push_instr(11'd1, 9'h0FF);
    push_instr(11'd2, 9'h100);
    void'(tx_q.pop_back());
    send_all(1'b0);
    send_byte(8'h01, 0);
    chk("last_wr_en", 32'(wr_en), 32'd1);
    chk("done_with_last_wr", 32'(done), 32'd1);
    end_check(1'b1, 1'b0);

    // Same image with random gaps between bytes.
    for (int r = 0; r < 3; r++) load_three(1'b1);

    // Vector table: one short image per entry.
    for (int i = 0; i < 8; i++) begin
      wr_t w;
      do_start();
      tx_q.push_back(tbl[i].c_lo);
      tx_q.push_back(tbl[i].c_hi);
      if (tbl[i].has_data) begin
        tx_q.push_back(tbl[i].d_lo);
        tx_q.push_back(tbl[i].d_hi);
        if (!tbl[i].exp_err) begin
          w.addr = '0;
          w.data = tbl[i].exp_data;
          exp_q.push_back(w);
        end
      end
      send_all(i[0]);
      end_check(!tbl[i].exp_err, tbl[i].exp_err);
    end

    // Full depth at full throughput.
    do_start();
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h08);
    for (int i = 0; i < 2048; i++) push_instr(11'(i), 9'(i * 37 + 5));
    send_all(1'b0);
    chk("full_depth_cycles", 32'(cyc - cyc_start), 32'(2 + 2 * 2048));
    chk("full_depth_last_addr", 32'(wr_addr), 32'd2047);
    end_check(1'b1, 1'b0);

    // Reset while waiting for a high byte.
    do_start();
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    push_instr(11'd0, 9'h112);
    tx_q.push_back(8'h34);
    send_all(1'b0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h01;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_wr_en", 32'(wr_en), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_pending", 32'(exp_q.size()), 32'd0);
    load_three(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
